// File: rtl/rf_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : rf_writeback_queue
// Purpose  : Write-side driver for the 16x32 register file. Takes results from
//            the EX and MEM stages, queues them in order in a small FIFO, and
//            presents at most one write per cycle on the register-file write
//            port (PW, C, RFLd). Exports a per-register pending mask so hazard
//            logic can stall reads of registers with writes still in flight.
// Ports    : CLK, RST          - clock (rising edge), synchronous active-high reset
//            mem_valid/rd/data - MEM stage result request; mem_ready accepts it
//            ex_valid/rd/data  - EX stage result request;  ex_ready accepts it
//            PW, C, RFLd       - register-file write data, select, enable
//            pc_redirect       - R15 is being written this cycle
//            pend              - bit r set while a queued/presented write targets Rr
//            count             - current FIFO occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          mem_valid,
  input  logic [3:0]    mem_rd,
  input  logic [31:0]   mem_data,
  output logic          mem_ready,
  input  logic          ex_valid,
  input  logic [3:0]    ex_rd,
  input  logic [31:0]   ex_data,
  output logic          ex_ready,
  output logic [31:0]   PW,
  output logic [3:0]    C,
  output logic          RFLd,
  output logic          pc_redirect,
  output logic [15:0]   pend,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   c_depth_cnt = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] c_depth_ext = (AW+2)'(DEPTH);

  logic [31:0]      r_data [DEPTH];
  logic [3:0]       r_rd   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;

  logic             w_mem_acc;
  logic             w_ex_acc;
  logic             w_pop;
  logic [AW-1:0]    w_ex_slot;
  logic [DEPTH-1:0] w_vld_nxt;
  logic [AW:0]      w_count_nxt;

  // Ready depends only on registered occupancy; a pop at the same edge does
  // not free space early. EX is judged after reserving room for MEM.
  assign mem_ready = (count < c_depth_cnt);
  assign ex_ready  = (({1'b0, count} + (AW+2)'(mem_valid)) < c_depth_ext);

  assign w_mem_acc = mem_valid & mem_ready;
  assign w_ex_acc  = ex_valid & ex_ready;
  assign w_pop     = (count != '0);

  // MEM is the older instruction, so it takes the first free slot.
  assign w_ex_slot = w_mem_acc ? (r_wr_ptr + 1'b1) : r_wr_ptr;

  assign w_count_nxt = count + (AW+1)'(w_mem_acc) + (AW+1)'(w_ex_acc)
                     - (AW+1)'(w_pop);

  // Writes only ever land on free slots (ready guarantees room), so clearing
  // the popped slot and setting the written ones cannot collide.
  always_comb begin
    w_vld_nxt = r_vld;
    if (w_pop)     w_vld_nxt[r_rd_ptr]  = 1'b0;
    if (w_mem_acc) w_vld_nxt[r_wr_ptr]  = 1'b1;
    if (w_ex_acc)  w_vld_nxt[w_ex_slot] = 1'b1;
  end

  // Storage needs no reset: validity is tracked separately.
  always_ff @(posedge CLK) begin
    if (w_mem_acc) begin
      r_data[r_wr_ptr] <= mem_data;
      r_rd[r_wr_ptr]   <= mem_rd;
    end
    if (w_ex_acc) begin
      r_data[w_ex_slot] <= ex_data;
      r_rd[w_ex_slot]   <= ex_rd;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      count    <= '0;
      PW       <= '0;
      C        <= '0;
      RFLd     <= 1'b0;
    end else begin
      r_vld    <= w_vld_nxt;
      r_wr_ptr <= r_wr_ptr + AW'(w_mem_acc) + AW'(w_ex_acc);
      count    <= w_count_nxt;
      if (w_pop) begin
        PW       <= r_data[r_rd_ptr];
        C        <= r_rd[r_rd_ptr];
        RFLd     <= 1'b1;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end else begin
        RFLd     <= 1'b0;
      end
    end
  end

  // Pending mask covers every queued entry plus the write on the port now.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) pend[r_rd[i]] = 1'b1;
    end
    if (RFLd) pend[C] = 1'b1;
  end

  assign pc_redirect = RFLd & (C == 4'b1111);

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_writeback_queue
// Purpose  : Self-checking bench for rf_writeback_queue. A queue-based
//            reference model predicts ready, write port, pending mask and
//            occupancy every cycle; directed scenarios are followed by
//            randomized traffic with occasional resets.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          mem_valid;
  logic [3:0]    mem_rd;
  logic [31:0]   mem_data;
  logic          mem_ready;
  logic          ex_valid;
  logic [3:0]    ex_rd;
  logic [31:0]   ex_data;
  logic          ex_ready;
  logic [31:0]   PW;
  logic [3:0]    C;
  logic          RFLd;
  logic          pc_redirect;
  logic [15:0]   pend;
  logic [AW:0]   count;

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .PW(PW), .C(C), .RFLd(RFLd), .pc_redirect(pc_redirect),
    .pend(pend), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;

  // Reference model: queue of waiting writes plus the write on the port.
  wr_t         m_q[$];
  logic        m_rfld;
  logic [31:0] m_pw;
  logic [3:0]  m_c;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pend();
    logic [15:0] p;
    p = '0;
    foreach (m_q[i]) p[m_q[i].rd] = 1'b1;
    if (m_rfld) p[m_c] = 1'b1;
    return p;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_rfld = 1'b0;
    m_pw   = '0;
    m_c    = '0;
  endfunction

  // Called at a negedge: drive a request pair, check all outputs, advance one edge.
  task automatic cycle(input logic mv, input logic [3:0] mrd, input logic [31:0] md,
                       input logic ev, input logic [3:0] erd, input logic [31:0] ed);
    logic exp_mr, exp_er;
    wr_t  e;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    ex_valid  = ev; ex_rd  = erd; ex_data  = ed;
    #1;
    exp_mr = (m_q.size() < DEPTH);
    exp_er = ((m_q.size() + int'(mv)) < DEPTH);
    chk("mem_ready",   32'(mem_ready),   32'(exp_mr));
    chk("ex_ready",    32'(ex_ready),    32'(exp_er));
    chk("RFLd",        32'(RFLd),        32'(m_rfld));
    chk("PW",          PW,               m_pw);
    chk("C",           32'(C),           32'(m_c));
    chk("pc_redirect", 32'(pc_redirect), 32'(m_rfld && (m_c == 4'd15)));
    chk("pend",        32'(pend),        32'(model_pend()));
    chk("count",       32'(count),       32'(m_q.size()));
    @(posedge CLK);
    if (m_q.size() > 0) begin
      e      = m_q.pop_front();
      m_rfld = 1'b1;
      m_pw   = e.data;
      m_c    = e.rd;
    end else begin
      m_rfld = 1'b0;
    end
    if (mv && exp_mr) m_q.push_back('{rd: mrd, data: md});
    if (ev && exp_er) m_q.push_back('{rd: erd, data: ed});
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    mem_valid = 1'($urandom_range(0, 1)); mem_rd = 4'($urandom()); mem_data = $urandom();
    ex_valid  = 1'($urandom_range(0, 1)); ex_rd  = 4'($urandom()); ex_data  = $urandom();
    @(posedge CLK);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    ex_valid  = 1'b0; ex_rd  = '0; ex_data  = '0;
    model_reset();
    @(negedge CLK);
    do_reset();
    idle(2);

    // Single MEM write: one-cycle latency to the port.
    cycle(1'b1, 4'd3, 32'h5A, 1'b0, 4'd0, 32'd0);
    idle(3);

    // Simultaneous MEM and EX: MEM retires first.
    cycle(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    idle(4);

    // Streaming EX writes with continuous drain.
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'(i), 32'h1000 + 32'(i));
    idle(3);

    // Two requests per cycle: fill, back-pressure, pointer wrap over several fills.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++)
        cycle(1'b1, 4'($urandom()), $urandom(), 1'b1, 4'($urandom()), $urandom());
      idle(6);
    end

    // R15 write raises pc_redirect alongside RFLd.
    cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h100);
    idle(3);

    // Reset with entries queued discards them.
    cycle(1'b1, 4'd4, 32'hA4, 1'b1, 4'd5, 32'hA5);
    cycle(1'b1, 4'd6, 32'hA6, 1'b1, 4'd7, 32'hA7);
    do_reset();
    idle(4);

    // Randomized traffic with varying load and rare resets.
    for (int i = 0; i < 600; i++) begin
      int load;
      load = (i / 100) % 3 + 1;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 3) < load), 4'($urandom()), $urandom(),
              1'($urandom_range(0, 3) < load), 4'($urandom()), $urandom());
      end
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
